rgmii_phy_tx: RTL and testbench
===============================

Name: rgmii_phy_tx

Overview:
- Transmit half of the RGMII PHY pair. Sits between a byte-wide MAC stream and the PHY TX pins.
- Frames the payload: inserts preamble and SFD, pads to the minimum length, appends the CRC-32 FCS and enforces the inter-frame gap.
- Each byte is split into two nibbles and sent through per-pin oddr primitives, DDR on phy_clk. The forwarded TX clock is also generated through an oddr.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before the 0xD5 SFD.
- MIN_FRAME, 60, minimum payload+pad bytes before the FCS; 0 disables padding.
- IFG_BYTES, 12, idle byte times after the FCS or after an abort.

Ports:
- phy_clk  input  1  125 MHz byte clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- s_data  input  8  payload byte.
- s_valid  input  1  s_data is valid.
- s_last  input  1  marks the final payload byte.
- s_ready  output  1  byte accepted when s_valid && s_ready.
- underrun  output  1  one-cycle pulse when a frame is aborted.
- phy_tx_clk  output  1  forwarded clock (oddr, D0=1, D1=0).
- phy_ctl  output  1  DDR: rising edge = tx_en; falling edge = tx_en^tx_er.
- phy_data  output  4  DDR: rising edge = byte[3:0]; falling edge = byte[7:4].

Behaviour:
- Core registers: tx_byte[7:0], tx_en, tx_er. These feed the oddr D0/D1 inputs.
- Reset values: tx_byte=0, tx_en=0, tx_er=0, s_ready=0, underrun=0. After reset the FSM enters IFG with a full count, so no frame starts before IFG_BYTES idle cycles.
- FSM states: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- IDLE: when s_valid=1, go to PRE. The first 0x55 appears on tx_byte the next cycle. s_valid is not consumed in IDLE.
- PRE: output 0x55 for PREAMBLE_LEN cycles, then go to SFD.
- SFD: output 0xD5 and raise s_ready for the next cycle.
- DATA:
  - s_ready=1. Each accepted byte appears on tx_byte one cycle later.
  - An 11-bit count of payload+pad bytes saturates at 2047.
  - On s_last: if count+1 < MIN_FRAME go to PAD, else go to FCS. s_ready drops the same cycle the last byte is accepted.
  - If s_valid=0 while in DATA: output one byte with tx_er=1, tx_en=1, pulse underrun, flush the CRC, go to IFG.
- PAD: output 0x00 until count reaches MIN_FRAME, then go to FCS. Pad bytes are included in the CRC.
- FCS:
  - Output ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24] in that order.
  - The CRC is frozen at FCS entry; the FCS bytes themselves are not fed into it.
- IFG: tx_en=0 and tx_byte=0 for IFG_BYTES cycles, then go to IDLE.
- tx_en is 1 in PRE, SFD, DATA, PAD and FCS; 0 otherwise.
- CRC-32 rules:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Reset to the init value in SFD.
  - Updated with every DATA and PAD byte in the same cycle the byte is registered.
- rst asserted mid-frame: all outputs return to reset values on the next edge. The frame is truncated on the wire with no FCS; no underrun pulse.
- An s_last on a non-accepted cycle is ignored.
- Back-to-back frames: s_valid held high after s_last starts the next preamble exactly IFG_BYTES cycles after the last FCS byte.

Decomposition:
- Package rgmii_pkg holds:
  - state enum;
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5;
  - CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF.
- Sub-module crc32_byte: combinational next-CRC over one byte. It is reusable later for RX FCS checking.
- oddr instances are generated per data bit, plus one each for ctl and clock, mirroring the RX iddr structure.

Test Plan:
- Reset then 1-byte frame 0xAB, s_last=1, default parameters -> after 12 IFG cycles:
  - 7×0x55, 0xD5, 0xAB, 59×0x00, 4 FCS bytes matching the software model;
  - tx_en high for exactly 72 cycles, then low for 12.
- MIN_FRAME=0, payload ASCII "123456789" -> FCS bytes 0x26, 0x39, 0xF4, 0xCB; no pad bytes.
- 64-byte payload 0x00..0x3F -> no pad; first FCS byte immediately follows 0x3F; s_ready high for exactly 64 cycles.
- s_valid dropped after byte 10 -> one byte with phy_ctl rise=1, fall=0 (tx_er); underrun pulses once; 12 idle cycles; next frame starts normally.
- Two frames back-to-back with s_valid held high -> exactly 12 tx_en=0 cycles between frames; both FCS values correct.
- rst pulsed during PAD -> phy_ctl=0 from the next cycle; s_ready=0; the next frame waits the full IFG_BYTES and is correct.

Source files
------------

// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII transmit path.
// The CRC constants are the reflected Ethernet CRC-32 values.
package rgmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  // FCS goes out least significant byte first, complemented.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    return ~crc[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational CRC-32 (reflected) update over one byte.
// Shared by the TX FCS generator and the future RX FCS checker.
module crc32_byte
  import rgmii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c_s;

  // Eight LSB-first shift/xor steps.
  always_comb begin
    c_s = crc_i ^ {24'd0, data_i};
    for (int i = 0; i < 8; i++) begin
      c_s = c_s[0] ? ((c_s >> 1) ^ CRC_POLY) : (c_s >> 1);
    end
    crc_o = c_s;
  end

endmodule

// File: rtl/oddr.sv
// Behavioural DDR output cell: d0 is driven while clk is high, d1 while clk is low.
// Both inputs are captured on the rising edge so the pair stays aligned.
module oddr (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d0_i,
  input  logic d1_i,
  output logic q_o
);

  logic d0_q;
  logic d1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d0_q <= 1'b0;
      d1_q <= 1'b0;
    end else begin
      d0_q <= d0_i;
      d1_q <= d1_i;
    end
  end

  assign q_o = clk_i ? d0_q : d1_q;

endmodule

// File: rtl/rgmii_phy_tx.sv
// RGMII transmit framer: preamble/SFD, payload, zero padding, CRC-32 FCS and
// inter-frame gap, serialised onto the DDR pins through per-pin oddr cells.
module rgmii_phy_tx
  import rgmii_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic       phy_clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       underrun,
  output logic       phy_tx_clk,
  output logic       phy_ctl,
  output logic [3:0] phy_data
);

  state_e      state_q;
  logic [7:0]  step_q;
  logic [10:0] byte_cnt_q;
  logic [10:0] byte_cnt_d;
  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [7:0]  crc_din_s;
  logic        short_s;
  logic [7:0]  tx_byte_q;
  logic        tx_en_q;
  logic        tx_er_q;
  logic        s_ready_q;
  logic        underrun_q;

  assign byte_cnt_d = (byte_cnt_q == 11'd2047) ? byte_cnt_q : (byte_cnt_q + 11'd1);
  assign short_s    = ({1'b0, byte_cnt_d} < 12'(MIN_FRAME));
  assign crc_din_s  = (state_q == ST_PAD) ? 8'h00 : s_data;

  crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (crc_din_s),
    .crc_o  (crc_d)
  );

  // Each transition registers the byte that belongs to the state being entered.
  always_ff @(posedge phy_clk) begin
    if (rst) begin
      state_q    <= ST_IFG;
      step_q     <= 8'(IFG_BYTES);
      byte_cnt_q <= 11'd0;
      crc_q      <= CRC_INIT;
      tx_byte_q  <= 8'h00;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      s_ready_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      tx_er_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s_valid) begin
            state_q   <= ST_PRE;
            step_q    <= 8'd1;
            tx_byte_q <= PREAMBLE_BYTE;
            tx_en_q   <= 1'b1;
          end else begin
            tx_byte_q <= 8'h00;
            tx_en_q   <= 1'b0;
          end
        end
        ST_PRE: begin
          tx_en_q <= 1'b1;
          if (step_q >= 8'(PREAMBLE_LEN)) begin
            state_q    <= ST_SFD;
            tx_byte_q  <= SFD_BYTE;
            s_ready_q  <= 1'b1;
            crc_q      <= CRC_INIT;
            byte_cnt_q <= 11'd0;
          end else begin
            tx_byte_q <= PREAMBLE_BYTE;
            step_q    <= step_q + 8'd1;
          end
        end
        ST_SFD, ST_DATA: begin
          if (s_valid) begin
            tx_byte_q  <= s_data;
            tx_en_q    <= 1'b1;
            crc_q      <= crc_d;
            byte_cnt_q <= byte_cnt_d;
            if (s_last) begin
              s_ready_q <= 1'b0;
              step_q    <= 8'd0;
              state_q   <= short_s ? ST_PAD : ST_FCS;
            end else begin
              state_q <= ST_DATA;
            end
          end else begin
            // Starved mid-frame: one errored byte, then a full gap.
            tx_byte_q  <= 8'h00;
            tx_en_q    <= 1'b1;
            tx_er_q    <= 1'b1;
            underrun_q <= 1'b1;
            s_ready_q  <= 1'b0;
            crc_q      <= CRC_INIT;
            state_q    <= ST_IFG;
            step_q     <= 8'(IFG_BYTES);
          end
        end
        ST_PAD: begin
          tx_byte_q  <= 8'h00;
          tx_en_q    <= 1'b1;
          crc_q      <= crc_d;
          byte_cnt_q <= byte_cnt_d;
          if (!short_s) begin
            state_q <= ST_FCS;
            step_q  <= 8'd0;
          end else begin
            state_q <= ST_PAD;
          end
        end
        ST_FCS: begin
          tx_byte_q <= fcs_byte(crc_q, step_q[1:0]);
          tx_en_q   <= 1'b1;
          if (step_q == 8'd3) begin
            state_q <= ST_IFG;
            step_q  <= 8'(IFG_BYTES);
          end else begin
            step_q <= step_q + 8'd1;
          end
        end
        ST_IFG: begin
          tx_byte_q <= 8'h00;
          tx_en_q   <= 1'b0;
          if (step_q <= 8'd1) begin
            state_q <= ST_IDLE;
          end else begin
            step_q <= step_q - 8'd1;
          end
        end
        default: begin
          state_q   <= ST_IFG;
          step_q    <= 8'(IFG_BYTES);
          tx_byte_q <= 8'h00;
          tx_en_q   <= 1'b0;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign underrun = underrun_q;

  for (genvar i = 0; i < 4; i++) begin : g_data
    oddr u_oddr_data (
      .clk_i (phy_clk),
      .rst_i (rst),
      .d0_i  (tx_byte_q[i]),
      .d1_i  (tx_byte_q[i+4]),
      .q_o   (phy_data[i])
    );
  end

  oddr u_oddr_ctl (
    .clk_i (phy_clk),
    .rst_i (rst),
    .d0_i  (tx_en_q),
    .d1_i  (tx_en_q ^ tx_er_q),
    .q_o   (phy_ctl)
  );

  // The forwarded clock keeps running through reset.
  oddr u_oddr_clk (
    .clk_i (phy_clk),
    .rst_i (1'b0),
    .d0_i  (1'b1),
    .d1_i  (1'b0),
    .q_o   (phy_tx_clk)
  );

endmodule

// File: tb/tb_rgmii_phy_tx.sv
// Directed bench for rgmii_phy_tx: captures the DDR pins of a padded and an
// unpadded instance and compares them against a bit-serial CRC-32 reference.
module tb_rgmii_phy_tx;

  typedef struct packed {
    logic       en;
    logic       ctlf;
    logic [7:0] b;
  } cap_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sd0 = 8'h00, sd1 = 8'h00;
  logic       sv0 = 1'b0, sv1 = 1'b0, sl0 = 1'b0, sl1 = 1'b0;
  logic       sr0, sr1, un0, un1, tc0, tc1, ctl0, ctl1;
  logic [3:0] pd0, pd1;

  int   checks = 0;
  int   failures = 0;
  cap_t cap0[$];
  cap_t cap1[$];
  logic rctl0, rctl1;
  logic [3:0] rlo0, rlo1;
  int   rdy_cnt0 = 0;
  int   un_cnt0 = 0;

  always #4 clk = ~clk;

  rgmii_phy_tx dut (
    .phy_clk(clk), .rst(rst), .s_data(sd0), .s_valid(sv0), .s_last(sl0),
    .s_ready(sr0), .underrun(un0), .phy_tx_clk(tc0), .phy_ctl(ctl0), .phy_data(pd0)
  );

  rgmii_phy_tx #(.MIN_FRAME(0)) dut_nopad (
    .phy_clk(clk), .rst(rst), .s_data(sd1), .s_valid(sv1), .s_last(sl1),
    .s_ready(sr1), .underrun(un1), .phy_tx_clk(tc1), .phy_ctl(ctl1), .phy_data(pd1)
  );

  // Rising-edge half of each DDR byte.
  always @(posedge clk) begin
    #1;
    rctl0 = ctl0; rlo0 = pd0;
    rctl1 = ctl1; rlo1 = pd1;
  end

  // Falling-edge half completes the byte record.
  always @(negedge clk) begin
    #1;
    cap0.push_back(cap_t'({rctl0, ctl0, pd0, rlo0}));
    cap1.push_back(cap_t'({rctl1, ctl1, pd1, rlo1}));
    if (sr0 === 1'b1) rdy_cnt0++;
    if (un0 === 1'b1) un_cnt0++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] crc_model(input logic [7:0] d[$]);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ d[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  function automatic cap_t cap_at(input cap_t c[$], input int i);
    cap_t r;
    r = 'x;
    if (i >= 0 && i < c.size()) r = c[i];
    return r;
  endfunction

  function automatic int gap_len(input cap_t c[$], input int from);
    int z;
    z = 0;
    for (int i = from; i < c.size(); i++) begin
      if (c[i].en !== 1'b0) break;
      z++;
    end
    return z;
  endfunction

  task automatic drive(input int u, input logic v, input logic [7:0] d, input logic l);
    if (u == 0) begin sv0 = v; sd0 = d; sl0 = l; end
    else        begin sv1 = v; sd1 = d; sl1 = l; end
  endtask

  // Streams b[] with a ready handshake; last_f marks s_last, hold_f keeps s_valid up.
  task automatic send_frame(input int u, input logic [7:0] b[$], input bit last_f, input bit hold_f);
    int idx, guard, n;
    logic rdy;
    n = b.size(); idx = 0; guard = 0;
    drive(u, 1'b1, b[0], last_f && n == 1);
    while (idx < n && guard < 400) begin
      @(negedge clk);
      rdy = (u == 0) ? sr0 : sr1;
      @(posedge clk);
      #1;
      guard++;
      if (rdy === 1'b1) begin
        idx++;
        if (idx < n) drive(u, 1'b1, b[idx], last_f && idx == n - 1);
        else if (!hold_f) drive(u, 1'b0, 8'h00, 1'b0);
      end
    end
    chk("send_in_time", 32'(guard < 400), 32'd1);
  endtask

  task automatic compare_seq(input cap_t c[$], input int from, input logic [7:0] want[$],
                             input string tag, output int s, output int e);
    s = -1;
    for (int i = from; i < c.size(); i++) begin
      if (c[i].en === 1'b1) begin s = i; break; end
    end
    chk({tag, "_found"}, 32'(s >= 0), 32'd1);
    e = from;
    if (s >= 0) begin
      for (int i = 0; i < want.size(); i++)
        chk($sformatf("%s_byte%0d", tag, i), 32'(cap_at(c, s + i)), {22'd0, 2'b11, want[i]});
      e = s + want.size();
    end
  endtask

  task automatic check_frame(input cap_t c[$], input int from, input logic [7:0] pay[$],
                             input int minf, input string tag, output int s, output int e);
    logic [7:0] body[$];
    logic [7:0] want[$];
    logic [31:0] crc;
    cap_t tail;
    body = pay;
    while (body.size() < minf) body.push_back(8'h00);
    crc = crc_model(body);
    for (int i = 0; i < 7; i++) want.push_back(8'h55);
    want.push_back(8'hD5);
    foreach (body[i]) want.push_back(body[i]);
    for (int k = 0; k < 4; k++) want.push_back(~crc[8*k +: 8]);
    compare_seq(c, from, want, tag, s, e);
    tail = cap_at(c, e);
    chk({tag, "_end"}, 32'(tail.en), 32'd0);
  endtask

  initial begin
    logic [7:0] pay[$];
    logic [7:0] pay2[$];
    logic [7:0] pre[$];
    cap_t r;
    int s, e, s2, e2;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(sr0), 32'd0);
    chk("rst_underrun", 32'(un0), 32'd0);
    chk("rst_underrun_nopad", 32'(un1), 32'd0);
    chk("rst_ctl_rise", 32'(ctl0), 32'd0);
    @(negedge clk); #1;
    chk("rst_ctl_fall", 32'(ctl0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cap0.delete(); cap1.delete();

    // 1-byte frame padded to 60, held off by the post-reset gap
    pay = {};
    pay.push_back(8'hAB);
    send_frame(0, pay, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("txclk_rise", 32'(tc0), 32'd1);
    chk("txclk_rise_nopad", 32'(tc1), 32'd1);
    @(negedge clk); #1;
    chk("txclk_fall", 32'(tc0), 32'd0);
    repeat (100) @(posedge clk);
    #1;
    check_frame(cap0, 0, pay, 60, "t1", s, e);
    chk("t1_startup_gap", 32'(s >= 12), 32'd1);
    chk("t1_run_len", 32'(e - s), 32'd72);
    chk("t1_ifg", 32'(gap_len(cap0, e) >= 12), 32'd1);

    // Check value "123456789" on the unpadded instance
    pay = {};
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    send_frame(1, pay, 1'b1, 1'b0);
    repeat (60) @(posedge clk);
    #1;
    check_frame(cap1, 0, pay, 0, "t2", s, e);
    r = cap_at(cap1, s + 17); chk("t2_fcs0", 32'(r.b), 32'h26);
    r = cap_at(cap1, s + 18); chk("t2_fcs1", 32'(r.b), 32'h39);
    r = cap_at(cap1, s + 19); chk("t2_fcs2", 32'(r.b), 32'hF4);
    r = cap_at(cap1, s + 20); chk("t2_fcs3", 32'(r.b), 32'hCB);

    // 64-byte payload: no padding, ready for exactly 64 cycles
    cap0.delete();
    rdy_cnt0 = 0;
    pay = {};
    for (int i = 0; i < 64; i++) pay.push_back(8'(i));
    send_frame(0, pay, 1'b1, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    check_frame(cap0, 0, pay, 60, "t3", s, e);
    chk("t3_ready_cycles", 32'(rdy_cnt0), 32'd64);

    // Starved after 10 bytes, then a normal frame
    cap0.delete();
    un_cnt0 = 0;
    pay = {};
    for (int i = 0; i < 10; i++) pay.push_back(8'hA0 + 8'(i));
    send_frame(0, pay, 1'b0, 1'b0);
    @(posedge clk); #1;
    pay2 = {};
    pay2.push_back(8'hC1); pay2.push_back(8'hC2); pay2.push_back(8'hC3);
    send_frame(0, pay2, 1'b1, 1'b0);
    repeat (110) @(posedge clk);
    #1;
    pre = {};
    for (int i = 0; i < 7; i++) pre.push_back(8'h55);
    pre.push_back(8'hD5);
    foreach (pay[i]) pre.push_back(pay[i]);
    compare_seq(cap0, 0, pre, "t4", s, e);
    r = cap_at(cap0, e);
    chk("t4_err_ctl", 32'({r.en, r.ctlf}), 32'd2);
    chk("t4_ifg", 32'(gap_len(cap0, e + 1)), 32'd12);
    check_frame(cap0, e + 1, pay2, 60, "t4b", s2, e2);
    chk("t4_underrun_pulses", 32'(un_cnt0), 32'd1);

    // Back-to-back frames with s_valid held high
    cap0.delete();
    pay = {};
    pay.push_back(8'h11); pay.push_back(8'h22); pay.push_back(8'h33);
    pay2 = {};
    for (int i = 0; i < 5; i++) pay2.push_back(8'hE0 + 8'(i));
    send_frame(0, pay, 1'b1, 1'b1);
    send_frame(0, pay2, 1'b1, 1'b0);
    repeat (120) @(posedge clk);
    #1;
    check_frame(cap0, 0, pay, 60, "t5a", s, e);
    chk("t5_gap", 32'(gap_len(cap0, e)), 32'd12);
    check_frame(cap0, e, pay2, 60, "t5b", s2, e2);

    // Reset pulsed while padding
    cap0.delete();
    un_cnt0 = 0;
    pay = {};
    pay.push_back(8'h5A);
    send_frame(0, pay, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_in_frame", 32'(ctl0), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_ctl_rise", 32'(ctl0), 32'd0);
    chk("t6_s_ready", 32'(sr0), 32'd0);
    @(negedge clk); #1;
    chk("t6_ctl_fall", 32'(ctl0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_no_underrun", 32'(un_cnt0), 32'd0);
    cap0.delete();
    pay = {};
    pay.push_back(8'h66); pay.push_back(8'h77);
    send_frame(0, pay, 1'b1, 1'b0);
    repeat (110) @(posedge clk);
    #1;
    check_frame(cap0, 0, pay, 60, "t6", s, e);
    chk("t6_startup_gap", 32'(s >= 12), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
